uart_rx_fsm: RTL

Receive-side counterpart of the UART transmit path. Recovers 8-bit frames (start, 8 data LSB-first, optional even parity, stop) from the serial line `rx` using an oversampling tick. Delivers a one-cycle `rx_valid` strobe with the byte and error flags to the host-side register block. Sits between the pad-side serial input and the UART status/data registers, sharing the baud generator with the transmitter.

---
 rtl/uart_rx_fsm_if.sv | 25 ++
 rtl/uart_rx_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm_if.sv
// Host-side receive bundle of uart_rx_fsm: received byte, completion strobe, error flags, busy.
// The receiver drives it through the master modport; the UART status/data registers read it through the slave modport.
interface uart_rx_fsm_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       rx_busy;

   modport master (
      output rx_data,
      output rx_valid,
      output parity_err,
      output frame_err,
      output rx_busy
   );

   modport slave (
      input rx_data,
      input rx_valid,
      input parity_err,
      input frame_err,
      input rx_busy
   );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start/data/parity/stop recovery with a one-cycle completion strobe.
// Define UART_RX_PARITY_EN to build in the even-parity bit; otherwise a frame is start, 8 data bits and stop.
//
// state  | meaning
// IDLE   | line idle; waiting for a low level while armed
// START  | qualifying the start bit at its mid-point
// DATA   | sampling 8 data bits LSB first
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then publishing the frame
module uart_rx_fsm #(
   parameter int OVERSAMPLE = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          baud_tick,
   input  logic          rx,
   uart_rx_fsm_if.master host
);

   localparam int              SW        = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0]   SCNT_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0]   SCNT_FULL = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic          rx_meta;
   logic          rxs;
   logic [SW-1:0] scnt;
   logic [2:0]    bcnt;
   logic [7:0]    data_sr;
   logic          armed;

   logic          scnt_clr;
   logic          bit_smp;
   logic          stop_smp;

   logic [7:0]    rx_data_q;
   logic          rx_valid_q;
   logic          frame_err_q;

`ifdef UART_RX_PARITY_EN
   logic          par_smp;
   logic          perr;
   logic          parity_err_q;
`endif

   // rx is asynchronous to clk; reset to the idle level so no false start follows reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      scnt_clr  = 1'b0;
      bit_smp   = 1'b0;
      stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_smp   = 1'b0;
`endif
      case (state)
         IDLE: begin
            scnt_clr = 1'b1;
            if (!rxs && armed) begin
               state_nxt = START;
            end
         end
         START: begin
            if (baud_tick && (scnt == SCNT_HALF)) begin
               scnt_clr  = 1'b1;
               state_nxt = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (baud_tick && (scnt == SCNT_FULL)) begin
               bit_smp = 1'b1;
               if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (baud_tick && (scnt == SCNT_FULL)) begin
               par_smp   = 1'b1;
               state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (baud_tick && (scnt == SCNT_FULL)) begin
               stop_smp  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // scnt is realigned to the start-bit mid-point, so every later wrap lands mid-bit
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scnt <= '0;
         bcnt <= 3'd0;
      end else if (scnt_clr) begin
         scnt <= '0;
         bcnt <= 3'd0;
      end else if (baud_tick) begin
         scnt <= scnt + 1'b1;
         if (bit_smp) begin
            bcnt <= bcnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_sr <= 8'h00;
      end else if (bit_smp) begin
         data_sr[bcnt] <= rxs;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perr <= 1'b0;
      end else if (par_smp) begin
         perr <= (^data_sr) ^ rxs;
      end
   end
`endif

   // A low stop bit disarms start detection until the line has been seen high,
   // so a break produces one errored frame instead of a stream of them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         armed <= 1'b1;
      end else if (stop_smp && !rxs) begin
         armed <= 1'b0;
      end else if ((state == IDLE) && rxs) begin
         armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_valid_q <= stop_smp;
         if (stop_smp) begin
            rx_data_q    <= data_sr;
            frame_err_q  <= ~rxs;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= perr;
`endif
         end
      end
   end

   assign host.rx_data    = rx_data_q;
   assign host.rx_valid   = rx_valid_q;
   assign host.frame_err  = frame_err_q;
   assign host.rx_busy    = (state != IDLE);
`ifdef UART_RX_PARITY_EN
   assign host.parity_err = parity_err_q;
`else
   assign host.parity_err = 1'b0;
`endif

endmodule
